// File: rtl/dsp_addsub_seq.sv
// dsp_addsub_seq: multi-cycle add/sub/compare unit.
// The WIDTH-bit operands are processed as NS = WIDTH/SLICE_W slices, one slice
// per clock. The carry between slices is held in a register. The unit
// produces a signed-overflow flag, a zero flag and signed/unsigned compare
// results.
//
// Ports:
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   in_valid / in_ready    operand handshake; in_ready is high only in IDLE
//   in_op                  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU
//   in_a, in_b             operands, sampled only on the accept edge
//   out_valid / out_ready  result handshake; outputs hold while stalled
//   out_result             sum / difference / {0..0, lt}
//   out_carry              ADD: carry out; SUB/SLT/SLTU: 1 = no borrow
//   out_zero               out_result == 0
//   out_ovf                signed overflow of the underlying add/sub
//
// Optional build macro: ADDSUB_SATURATE_EN. When it is defined, an ADD or SUB
// that overflows is clamped to the signed max/min value.
module dsp_addsub_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int unsigned NS = WIDTH / SLICE_W;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01,
                            OP_SLT = 2'b10, OP_SLTU = 2'b11} op_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  op_t              op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             last_slice;
  logic [SLICE_W:0] slice_sum;
  logic [WIDTH-1:0] full_sum;
  logic [WIDTH-1:0] final_res;
  logic             sum_msb, a_msb, b_msb, ovf, lt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_BUSY;
      S_BUSY: if (last_slice) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign last_slice = (cnt_q == CW'(NS - 1));
  assign slice_sum  = {1'b0, a_q[cnt_q*SLICE_W +: SLICE_W]}
                    + {1'b0, b_q[cnt_q*SLICE_W +: SLICE_W]}
                    + {{SLICE_W{1'b0}}, carry_q};

  // The flags are only used on the last slice. By then, sum_q holds every lower
  // slice, so merging in the current slice gives the complete sum.
  always_comb begin
    full_sum = sum_q;
    full_sum[cnt_q*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
  end

  assign sum_msb = slice_sum[SLICE_W-1];
  assign a_msb   = a_q[WIDTH-1];
  assign b_msb   = b_q[WIDTH-1];
  assign ovf     = (a_msb == b_msb) && (sum_msb != a_msb);
  assign lt      = (op_q == OP_SLT) ? (sum_msb ^ ovf) : ~slice_sum[SLICE_W];

  always_comb begin
    final_res = '0;
    if (op_q == OP_SLT || op_q == OP_SLTU) begin
      final_res[0] = lt;
    end else begin
      final_res = full_sum;
`ifdef ADDSUB_SATURATE_EN
      if (ovf) final_res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      op_q       <= OP_ADD;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          // SUB and the compares are computed as a + ~b + 1.
          a_q     <= in_a;
          b_q     <= (op_t'(in_op) == OP_ADD) ? in_b : ~in_b;
          op_q    <= op_t'(in_op);
          carry_q <= (op_t'(in_op) != OP_ADD);
          cnt_q   <= '0;
          sum_q   <= '0;
        end
        S_BUSY: begin
          sum_q[cnt_q*SLICE_W +: SLICE_W] <= slice_sum[SLICE_W-1:0];
          carry_q <= slice_sum[SLICE_W];
          cnt_q   <= cnt_q + 1'b1;
          if (last_slice) begin
            out_result <= final_res;
            out_carry  <= slice_sum[SLICE_W];
            out_zero   <= (final_res == '0);
            out_ovf    <= ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_addsub_seq.sv
module tb_dsp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry, out_zero, out_ovf;

  always #5 clk = ~clk;

  dsp_addsub_seq #(.WIDTH(32), .SLICE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_ovf(out_ovf)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        c, z, v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, SLT = 2'b10, SLTU = 2'b11;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`else
  localparam logic [31:0] OVF_POS = 32'h8000_0000;
  localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every result that the DUT hands over.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h required=none", out_result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, out_result, mon_e.res);
        chk({mon_e.name, "_carry"}, 32'(out_carry), 32'(mon_e.c));
        chk({mon_e.name, "_zero"}, 32'(out_zero), 32'(mon_e.z));
        chk({mon_e.name, "_ovf"}, 32'(out_ovf), 32'(mon_e.v));
      end
    end
  end

  // Drives one operation. It returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name, input logic [31:0] res,
                       input logic c, input logic z, input logic v, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
    e.name = name; e.res = res; e.c = c; e.z = z; e.v = v;
    if (push) sb.push_back(e);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((in_ready !== 1'b1 || sb.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_op = ADD; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_carry, out_zero, out_ovf}, 32'd0);
    rst_n = 1'b1;

    // 1: slice carry and latency
    issue(ADD, 32'h0000_FFFF, 32'h0000_0001, "add_ffff", 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lat_in_ready_busy", 32'(in_ready), 32'd0);
    @(posedge clk); #1 chk("lat_valid_e1", 32'(out_valid), 32'd0);
    @(posedge clk); #1 chk("lat_valid_e2", 32'(out_valid), 32'd1);
    wait_idle("add_ffff");

    // 2: subtraction
    issue(SUB, 32'd7, 32'd7, "sub_7_7", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle("sub_7_7");
    issue(SUB, 32'd5, 32'd7, "sub_5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle("sub_5_7");

    // 3: overflow (and saturation when enabled)
    issue(ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf", OVF_POS, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle("add_ovf");
    issue(SUB, 32'h8000_0000, 32'd1, "sub_ovf", OVF_NEG, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle("sub_ovf");
    issue(ADD, 32'hFFFF_FFFF, 32'd1, "add_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle("add_wrap");

    // 4: compares
    issue(SLT, 32'hFFFF_FFFF, 32'd1, "slt", 32'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle("slt");
    issue(SLTU, 32'hFFFF_FFFF, 32'd1, "sltu", 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle("sltu");

    // 5: output stall in DONE
    out_ready = 1'b0;
    issue(ADD, 32'h1234_5678, 32'h1111_1111, "stall", 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("stall_valid_timeout", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_result", out_result, 32'h2345_6789);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      in_a = 32'(i) * 32'h0101_0101;
      in_op = SUB;
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_idle("stall");
    issue(ADD, 32'hFFFF_FFFF, 32'h0000_0002, "after_stall", 32'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle("after_stall");

    // 6: reset in the middle of BUSY discards the operation
    issue(ADD, 32'h100, 32'h200, "dropped", 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_result", 32'(out_valid), 32'd0);
    issue(ADD, 32'd3, 32'd4, "add_3_4", 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle("add_3_4");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
